// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
// Holds the op codes, the FSM state encoding, divide timing and sign helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // 32 iterations plus one sign-fix cycle
    localparam int DIV_CYCLES = 33;
    localparam int DIV_ITERS  = DIV_CYCLES - 1;

    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic div0;
    } div_ctl_t;

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// Latency: 32 cycles after start; done is high during the last iteration cycle.
// Backpressure: none; abort kills a running divide, start is ignored while running.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    logic        run;
    logic [4:0]  cnt;
    logic [31:0] dsr;
    logic [32:0] r_sh;
    logic [32:0] diff;

    // quotient doubles as the dividend shift register; its MSB feeds the remainder
    assign r_sh = {remainder, quotient[31]};
    assign diff = r_sh - {1'b0, dsr};
    assign done = run && (cnt == LAST_ITER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run       <= 1'b0;
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start && !run) begin
            run       <= 1'b1;
            cnt       <= '0;
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (run) begin
            if (!diff[32]) begin
                remainder <= diff[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= r_sh[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
            if (cnt == LAST_ITER) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit with MTHI/MTLO writes.
// Latency: MUL_CYCLES for MULT/MULTU, 33 for DIV/DIVU, MTHI/MTLO at acceptance.
// Backpressure: busy stalls the pipeline (exe_out_en = ~busy); start ignored while busy.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        exe_out_en,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    state_e      state;
    logic [1:0]  mul_cnt;
    div_ctl_t    div_ctl;

    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        div_signed;

    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] mul_prod;
    logic [1:0]         mul_prod_unused;
    logic [63:0]        mul_pipe [MUL_CYCLES];

    logic        div_start;
    logic        div_last;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] dvd_mag;
    logic [31:0] dsr_mag;

    assign accept     = start && !flush && (state == ST_IDLE);
    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
    assign div_signed = (op == OP_DIV);
    assign exe_out_en = ~busy;

    // One 33x33 signed multiplier covers both MULT and MULTU via the extension bit
    assign mul_a           = {(op == OP_MULT) && src1[31], src1};
    assign mul_b           = {(op == OP_MULT) && src2[31], src2};
    assign mul_prod        = mul_a * mul_b;
    assign mul_prod_unused = mul_prod[65:64];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_CYCLES; i++) begin
                mul_pipe[i] <= '0;
            end
        end else begin
            if (accept && is_mul) begin
                mul_pipe[0] <= mul_prod[63:0];
            end
            for (int i = 1; i < MUL_CYCLES; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
    end

    assign dvd_mag   = apply_sign(src1, div_signed && src1[31]);
    assign dsr_mag   = apply_sign(src2, div_signed && src2[31]);
    assign div_start = accept && is_div;

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (dvd_mag),
        .divisor   (dsr_mag),
        .done      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            mul_cnt <= '0;
            div_ctl <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state   <= ST_MUL;
                                busy    <= 1'b1;
                                mul_cnt <= 2'(MUL_CYCLES - 1);
                            end
                            OP_DIV, OP_DIVU: begin
                                state         <= ST_DIV;
                                busy          <= 1'b1;
                                div_ctl.q_neg <= div_signed && (src1[31] ^ src2[31]);
                                div_ctl.r_neg <= div_signed && src1[31];
                                div_ctl.div0  <= (src2 == 32'd0);
                            end
                            OP_MTHI: hi <= src1;
                            OP_MTLO: lo <= src1;
                            default: ;
                        endcase
                    end
                end
                // a completing write wins over a coincident flush
                ST_MUL: begin
                    if (mul_cnt == 2'd0) begin
                        {hi, lo} <= mul_pipe[MUL_CYCLES-1];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (flush) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        mul_cnt <= mul_cnt - 2'd1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (div_last) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi    <= apply_sign(div_rem, div_ctl.r_neg);
                    lo    <= div_ctl.div0 ? '1 : apply_sign(div_quo, div_ctl.q_neg);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
